// File: rtl/ctrl_pila_if.sv
// ctrl_pila_if: bus between the ctrl_pila sequencer (master) and the
// return-address stack (slave). The stack stores dato+1 on push and presents
// its current top word on stack_top.
interface ctrl_pila_if #(
  parameter int AW = 10
);
  logic          push;
  logic          pop;
  logic          s_intr;
  logic [AW-1:0] dato;
  logic [AW-1:0] stack_top;

  modport master (
    output push,
    output pop,
    output s_intr,
    output dato,
    input  stack_top
  );

  modport slave (
    input  push,
    input  pop,
    input  s_intr,
    input  dato,
    output stack_top
  );
endinterface

// File: rtl/ctrl_pila.sv
// ctrl_pila: CALL / RET / interrupt-entry / RETI sequencer for the
// return-address stack. Produces PC load requests and a fetch stall, tracks
// stack depth, flags overflow/underflow and gates interrupts.
// Optional build macro: NESTED_IRQ_EN -- in_isr becomes a nesting counter and
// interrupts stay enabled inside an ISR (default build: single-level ISR).
module ctrl_pila #(
  parameter int            AW       = 10,
  parameter int            DEPTH    = 16,
  parameter logic [AW-1:0] VEC_ADDR = 10'h3F0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   call,
  input  logic                   ret,
  input  logic                   reti,
  input  logic                   irq,
  input  logic [AW-1:0]          pc_actual,
  input  logic [AW-1:0]          dest,
  ctrl_pila_if.master            stk,
  output logic                   pc_load,
  output logic [AW-1:0]          pc_target,
  output logic                   stall,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   in_isr
);

  localparam int            DW     = $clog2(DEPTH) + 1;
  // Slot 0 of the stack is never written, so one word less is usable.
  localparam logic [DW-1:0] FULL   = DW'(DEPTH - 1);
  localparam logic [DW-1:0] ONE    = DW'(1);
  localparam logic [DW-1:0] ZERO   = {DW{1'b0}};
  localparam logic [AW-1:0] PC_ONE = AW'(1);
  localparam logic [AW-1:0] PC_Z   = {AW{1'b0}};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RET_RD   = 3'd1,
    RET_JMP  = 3'd2,
    INT_PUSH = 3'd3,
    INT_JMP  = 3'd4
  } state_t;

  state_t        state_r;
  logic [DW-1:0] depth_r;
  logic          overflow_r;
  logic          underflow_r;
  logic          irq_pend_r;
  logic          ie_r;
  logic          reti_l_r;
  logic [AW-1:0] ret_addr_r;
`ifdef NESTED_IRQ_EN
  logic [DW-1:0] isr_cnt_r;
`else
  logic          isr_r;
`endif

  logic          has_room_s;
  logic          ret_any_s;
  logic          call_ok_s;
  logic          isr_free_s;
  logic          in_isr_s;
  logic          push_s;
  logic          pop_s;
  logic          s_intr_s;
  logic          pc_load_s;
  logic          stall_s;
  logic [AW-1:0] dato_s;
  logic [AW-1:0] pc_target_s;

  assign has_room_s = (depth_r < FULL);
  assign ret_any_s  = ret | reti;
  // RET/RETI outrank CALL; a refused CALL (stack full) produces no strobes.
  assign call_ok_s  = call & ~ret_any_s & has_room_s;

`ifdef NESTED_IRQ_EN
  assign in_isr_s   = (isr_cnt_r != ZERO);
  assign isr_free_s = 1'b1;
`else
  assign in_isr_s   = isr_r;
  assign isr_free_s = ~isr_r;
`endif

  // Sequencer state, depth counter, sticky flags and interrupt bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      depth_r     <= ZERO;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      irq_pend_r  <= 1'b0;
      ie_r        <= 1'b1;
      reti_l_r    <= 1'b0;
      ret_addr_r  <= PC_Z;
`ifdef NESTED_IRQ_EN
      isr_cnt_r   <= ZERO;
`else
      isr_r       <= 1'b0;
`endif
    end else begin
      // A request is latched whenever interrupts are enabled; the entry into
      // INT_PUSH below overrides this with a clear.
      if (irq && ie_r) begin
        irq_pend_r <= 1'b1;
      end else begin
        irq_pend_r <= irq_pend_r;
      end

      case (state_r)
        IDLE: begin
          if (ret_any_s) begin
            if (depth_r == ZERO) begin
              underflow_r <= 1'b1;
            end else begin
              reti_l_r <= reti;
              state_r  <= RET_RD;
            end
          end else if (call) begin
            if (has_room_s) begin
              depth_r <= depth_r + ONE;
            end else begin
              overflow_r <= 1'b1;
            end
          end else if (irq_pend_r && isr_free_s) begin
            if (has_room_s) begin
              irq_pend_r <= 1'b0;
              state_r    <= INT_PUSH;
            end else begin
              // No room for the return frame: keep the request pending.
              overflow_r <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RET_RD: begin
          ret_addr_r <= stk.stack_top;
          depth_r    <= depth_r - ONE;
          state_r    <= RET_JMP;
        end
        RET_JMP: begin
          if (reti_l_r) begin
            ie_r <= 1'b1;
`ifdef NESTED_IRQ_EN
            if (isr_cnt_r != ZERO) begin
              isr_cnt_r <= isr_cnt_r - ONE;
            end else begin
              isr_cnt_r <= isr_cnt_r;
            end
`else
            isr_r <= 1'b0;
`endif
          end else begin
            ie_r <= ie_r;
          end
          state_r <= IDLE;
        end
        INT_PUSH: begin
          depth_r <= depth_r + ONE;
          state_r <= INT_JMP;
        end
        INT_JMP: begin
`ifdef NESTED_IRQ_EN
          if (isr_cnt_r != FULL) begin
            isr_cnt_r <= isr_cnt_r + ONE;
          end else begin
            isr_cnt_r <= isr_cnt_r;
          end
`else
          isr_r <= 1'b1;
          ie_r  <= 1'b0;
`endif
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Strobe decode from the current state (plus decoder inputs while IDLE).
  always_comb begin
    push_s      = 1'b0;
    pop_s       = 1'b0;
    s_intr_s    = 1'b0;
    pc_load_s   = 1'b0;
    stall_s     = 1'b0;
    dato_s      = PC_Z;
    pc_target_s = PC_Z;
    case (state_r)
      IDLE: begin
        push_s      = call_ok_s;
        pc_load_s   = call_ok_s;
        dato_s      = call_ok_s ? pc_actual : PC_Z;
        pc_target_s = call_ok_s ? dest : PC_Z;
      end
      RET_RD: begin
        stall_s  = 1'b1;
        pop_s    = 1'b1;
        s_intr_s = reti_l_r;
      end
      RET_JMP: begin
        stall_s     = 1'b1;
        pc_load_s   = 1'b1;
        pc_target_s = ret_addr_r;
      end
      INT_PUSH: begin
        // The stack stores dato+1, so it ends up holding pc_actual itself.
        stall_s = 1'b1;
        push_s  = 1'b1;
        dato_s  = pc_actual - PC_ONE;
      end
      INT_JMP: begin
        stall_s     = 1'b1;
        pc_load_s   = 1'b1;
        pc_target_s = VEC_ADDR;
      end
      default: begin
        stall_s = 1'b0;
      end
    endcase
  end

  // While reset is asserted nothing leaves the block, even a decoded CALL.
  assign stk.push   = push_s & reset;
  assign stk.pop    = pop_s & reset;
  assign stk.s_intr = s_intr_s & reset;
  assign stk.dato   = reset ? dato_s : PC_Z;
  assign pc_load    = pc_load_s & reset;
  assign pc_target  = reset ? pc_target_s : PC_Z;
  assign stall      = stall_s & reset;

  assign depth      = depth_r;
  assign overflow   = overflow_r;
  assign underflow  = underflow_r;
  assign in_isr     = in_isr_s;

endmodule

// File: tb/tb_ctrl_pila.sv
// tb_ctrl_pila: self-checking bench for ctrl_pila (default build).
// The reference model is transaction level: a queue holds the words the
// stack should contain (CALL stores pc+1, interrupt entry stores pc), plus
// sticky flags, ISR/pending bits. Each operation task drives one instruction
// and checks the cycle-by-cycle strobes the rules demand.
module tb_ctrl_pila;
  localparam int AW    = 10;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          call = 1'b0;
  logic          ret = 1'b0;
  logic          reti = 1'b0;
  logic          irq = 1'b0;
  logic [AW-1:0] pc_actual = 10'h000;
  logic [AW-1:0] dest = 10'h000;
  logic          pc_load;
  logic [AW-1:0] pc_target;
  logic          stall;
  logic [4:0]    depth;
  logic          overflow;
  logic          underflow;
  logic          in_isr;

  ctrl_pila_if #(.AW(AW)) stk ();

  ctrl_pila #(.AW(AW), .DEPTH(DEPTH), .VEC_ADDR(10'h3F0)) dut (
    .clk(clk), .reset(reset), .call(call), .ret(ret), .reti(reti), .irq(irq),
    .pc_actual(pc_actual), .dest(dest), .stk(stk), .pc_load(pc_load),
    .pc_target(pc_target), .stall(stall), .depth(depth), .overflow(overflow),
    .underflow(underflow), .in_isr(in_isr)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [AW-1:0] m_q[$];
  logic          m_ovf;
  logic          m_unf;
  logic          m_isr;
  logic          m_pend;

  int checks = 0;
  int failures = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_clear;
    m_q.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_isr = 1'b0; m_pend = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b0; call = 1'b0; ret = 1'b0; reti = 1'b0; irq = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  // Interrupt entry; raise=0 means the request is already pending.
  task automatic op_irq(input string tag, input logic raise, input logic [AW-1:0] pc,
                        input logic second);
    logic [AW-1:0] exp_d;
    logic [4:0]    md;
    exp_d = pc - 10'd1;
    @(negedge clk);
    pc_actual = pc;
    if (raise) begin
      irq = 1'b1;
      #1;
      checks++;
      if ({stk.push, stk.pop, pc_load, stall} !== 4'b0000)
        begin failures++; $display("FAIL %s irq_latch: strobes push/pop/load/stall=%b want 0000", tag, {stk.push, stk.pop, pc_load, stall}); end
      @(posedge clk); #1;
      irq = 1'b0;
      m_pend = 1'b1;
      @(negedge clk);
    end
    #1;
    md = 5'(m_q.size());
    checks++;
    if ({stk.push, stk.pop, pc_load, stall, depth, overflow, underflow, in_isr} !== {4'b0000, md, m_ovf, m_unf, m_isr})
      begin failures++; $display("FAIL %s irq_pend: strobes=%b depth=%0d ovf=%b unf=%b isr=%b want strobes=0000 depth=%0d ovf=%b unf=%b isr=%b",
        tag, {stk.push, stk.pop, pc_load, stall}, depth, overflow, underflow, in_isr, md, m_ovf, m_unf, m_isr); end
    if (m_q.size() >= DEPTH - 1) begin
      @(posedge clk); #1;
      m_ovf = 1'b1;
    end else begin
      @(posedge clk); #1;
      m_pend = 1'b0;
      irq = second;
      @(negedge clk); #1;
      checks++;
      if ({stall, stk.push, stk.pop, pc_load} !== 4'b1100 || stk.dato !== exp_d)
        begin failures++; $display("FAIL %s int_push: stall/push/pop/load=%b dato=%h want 1100 dato=%h", tag, {stall, stk.push, stk.pop, pc_load}, stk.dato, exp_d); end
      @(posedge clk); #1;
      irq = 1'b0;
      if (second) m_pend = 1'b1;
      @(negedge clk); #1;
      checks++;
      if ({stall, pc_load, stk.push, stk.pop} !== 4'b1100 || pc_target !== 10'h3F0)
        begin failures++; $display("FAIL %s int_jmp: stall/load/push/pop=%b target=%h want 1100 target=3f0", tag, {stall, pc_load, stk.push, stk.pop}, pc_target); end
      @(posedge clk); #1;
      m_q.push_back(pc);
      m_isr = 1'b1;
    end
  endtask

  task automatic op_call(input string tag, input logic [AW-1:0] pc, input logic [AW-1:0] d);
    logic          ok;
    logic [AW-1:0] stored;
    logic [4:0]    md;
    @(negedge clk);
    call = 1'b1; pc_actual = pc; dest = d;
    #1;
    ok = (m_q.size() < DEPTH - 1);
    md = 5'(m_q.size());
    checks++;
    if ({depth, overflow, underflow, in_isr} !== {md, m_ovf, m_unf, m_isr})
      begin failures++; $display("FAIL %s status: depth=%0d ovf=%b unf=%b isr=%b want depth=%0d ovf=%b unf=%b isr=%b",
        tag, depth, overflow, underflow, in_isr, md, m_ovf, m_unf, m_isr); end
    checks++;
    if ({stk.push, stk.pop, stall, pc_load} !== {ok, 1'b0, 1'b0, ok})
      begin failures++; $display("FAIL %s call_strobes: push/pop/stall/load=%b want %b", tag, {stk.push, stk.pop, stall, pc_load}, {ok, 1'b0, 1'b0, ok}); end
    if (ok) begin
      checks++;
      if (stk.dato !== pc || pc_target !== d)
        begin failures++; $display("FAIL %s call_data: dato=%h target=%h want dato=%h target=%h", tag, stk.dato, pc_target, pc, d); end
    end
    @(posedge clk); #1;
    call = 1'b0;
    stored = pc + 10'd1;
    if (ok) m_q.push_back(stored);
    else m_ovf = 1'b1;
  endtask

  task automatic op_ret(input string tag, input logic is_reti, input logic with_call);
    logic [AW-1:0] exp_t;
    logic          empty;
    logic [4:0]    md;
    @(negedge clk);
    ret = ~is_reti; reti = is_reti; call = with_call;
    pc_actual = AW'($urandom); dest = AW'($urandom);
    empty = (m_q.size() == 0);
    exp_t = empty ? AW'($urandom) : m_q[$];
    stk.stack_top = exp_t;
    #1;
    md = 5'(m_q.size());
    checks++;
    if ({depth, overflow, underflow, in_isr} !== {md, m_ovf, m_unf, m_isr})
      begin failures++; $display("FAIL %s status: depth=%0d ovf=%b unf=%b isr=%b want depth=%0d ovf=%b unf=%b isr=%b",
        tag, depth, overflow, underflow, in_isr, md, m_ovf, m_unf, m_isr); end
    checks++;
    if ({stk.push, stk.pop, stk.s_intr, pc_load, stall} !== 5'b00000)
      begin failures++; $display("FAIL %s ret_decode: push/pop/s_intr/load/stall=%b want 00000", tag, {stk.push, stk.pop, stk.s_intr, pc_load, stall}); end
    @(posedge clk); #1;
    ret = 1'b0; reti = 1'b0; call = 1'b0;
    if (empty) begin
      m_unf = 1'b1;
    end else begin
      @(negedge clk); #1;
      checks++;
      if ({stall, stk.pop, stk.s_intr, stk.push, pc_load} !== {1'b1, 1'b1, is_reti, 1'b0, 1'b0})
        begin failures++; $display("FAIL %s ret_rd: stall/pop/s_intr/push/load=%b want %b", tag, {stall, stk.pop, stk.s_intr, stk.push, pc_load}, {1'b1, 1'b1, is_reti, 1'b0, 1'b0}); end
      @(posedge clk); #1;
      stk.stack_top = AW'($urandom);
      @(negedge clk); #1;
      checks++;
      if ({stall, pc_load, stk.pop, stk.push} !== 4'b1100 || pc_target !== exp_t)
        begin failures++; $display("FAIL %s ret_jmp: stall/load/pop/push=%b target=%h want 1100 target=%h", tag, {stall, pc_load, stk.pop, stk.push}, pc_target, exp_t); end
      @(posedge clk); #1;
      void'(m_q.pop_back());
      if (is_reti) m_isr = 1'b0;
      if (m_pend && !m_isr) op_irq({tag, "_pend"}, 1'b0, AW'($urandom), 1'b0);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; call = 1'b1; ret = 1'b0; reti = 1'b0; irq = 1'b0;
    pc_actual = 10'h155; dest = 10'h2AA; stk.stack_top = 10'h000;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({stk.push, stk.pop, stk.s_intr, pc_load, stall} !== 5'b00000 || stk.dato !== 10'h000 || pc_target !== 10'h000)
      begin failures++; $display("FAIL reset_strobes: strobes=%b dato=%h target=%h want 00000 000 000", {stk.push, stk.pop, stk.s_intr, pc_load, stall}, stk.dato, pc_target); end
    checks++;
    if ({depth, overflow, underflow, in_isr} !== 8'h00)
      begin failures++; $display("FAIL reset_status: depth=%0d ovf=%b unf=%b isr=%b want all 0", depth, overflow, underflow, in_isr); end
    call = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_call_ret;
    do_reset();
    op_call("call", 10'h010, 10'h100);
    op_ret("ret", 1'b0, 1'b0);
    @(negedge clk); #1;
    checks++;
    if (depth !== 5'd0 || stall !== 1'b0)
      begin failures++; $display("FAIL call_ret_end: depth=%0d stall=%b want 0 0", depth, stall); end
  endtask

  task automatic test_irq_reti;
    do_reset();
    op_irq("irq", 1'b1, 10'h020, 1'b1);
    op_ret("reti", 1'b1, 1'b0);
    op_ret("reti2", 1'b1, 1'b0);
    op_irq("irq_pc0", 1'b1, 10'h000, 1'b0);
    op_ret("reti_pc0", 1'b1, 1'b0);
    @(negedge clk); #1;
    checks++;
    if ({depth, in_isr, overflow, underflow} !== 8'h00)
      begin failures++; $display("FAIL irq_end: depth=%0d isr=%b ovf=%b unf=%b want 0", depth, in_isr, overflow, underflow); end
  endtask

  task automatic test_overflow;
    do_reset();
    for (int i = 0; i < 15; i++) op_call("fill", AW'($urandom), AW'($urandom));
    op_call("call16", 10'h123, 10'h321);
    @(negedge clk); #1;
    checks++;
    if (depth !== 5'd15 || overflow !== 1'b1)
      begin failures++; $display("FAIL overflow_flag: depth=%0d ovf=%b want 15 1", depth, overflow); end
    op_irq("irq_full", 1'b1, 10'h0AA, 1'b0);
    op_ret("ret_full", 1'b0, 1'b0);
    @(negedge clk); #1;
    checks++;
    if (depth !== 5'd15 || in_isr !== 1'b1 || overflow !== 1'b1)
      begin failures++; $display("FAIL overflow_irq_served: depth=%0d isr=%b ovf=%b want 15 1 1", depth, in_isr, overflow); end
  endtask

  task automatic test_underflow_priority;
    do_reset();
    op_ret("unf", 1'b0, 1'b0);
    op_call("c1", 10'h050, 10'h200);
    op_ret("callret", 1'b0, 1'b1);
    @(negedge clk); #1;
    checks++;
    if (depth !== 5'd0 || underflow !== 1'b1 || overflow !== 1'b0)
      begin failures++; $display("FAIL underflow_end: depth=%0d unf=%b ovf=%b want 0 1 0", depth, underflow, overflow); end
  endtask

  task automatic test_async_reset;
    do_reset();
    op_ret("pre_unf", 1'b0, 1'b0);
    op_call("pre_call", 10'h0F0, 10'h0F8);
    @(negedge clk);
    ret = 1'b1; stk.stack_top = m_q[$];
    @(posedge clk); #1;
    ret = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({stk.pop, stall} !== 2'b11)
      begin failures++; $display("FAIL rst_pre: pop/stall=%b want 11", {stk.pop, stall}); end
    reset = 1'b0;
    #1;
    checks++;
    if ({stk.pop, stall, stk.push, pc_load, stk.s_intr, depth, overflow, underflow, in_isr} !== 13'h0000)
      begin failures++; $display("FAIL rst_async: pop=%b stall=%b push=%b load=%b depth=%0d ovf=%b unf=%b isr=%b want all 0",
        stk.pop, stall, stk.push, pc_load, depth, overflow, underflow, in_isr); end
    @(posedge clk); #1;
    checks++;
    if ({stk.pop, stall, pc_load} !== 3'b000)
      begin failures++; $display("FAIL rst_hold: pop/stall/load=%b want 000", {stk.pop, stall, pc_load}); end
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    op_call("post_rst", 10'h011, 10'h022);
  endtask

  task automatic test_random;
    int sel;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 15 && !m_isr && m_q.size() < DEPTH - 1)
        op_irq("rnd_irq", 1'b1, AW'($urandom), ($urandom_range(0, 2) == 0));
      else if (sel < 55)
        op_call("rnd_call", AW'($urandom), AW'($urandom));
      else if (sel < 82)
        op_ret("rnd_ret", 1'b0, ($urandom_range(0, 3) == 0));
      else
        op_ret("rnd_reti", 1'b1, 1'b0);
    end
    @(negedge clk); #1;
    checks++;
    if ({depth, overflow, underflow, in_isr} !== {5'(m_q.size()), m_ovf, m_unf, m_isr})
      begin failures++; $display("FAIL rnd_end: depth=%0d ovf=%b unf=%b isr=%b want depth=%0d ovf=%b unf=%b isr=%b",
        depth, overflow, underflow, in_isr, m_q.size(), m_ovf, m_unf, m_isr); end
  endtask

  initial begin
    stk.stack_top = 10'h000;
    model_clear();
    test_reset();
    test_call_ret();
    test_irq_reti();
    test_overflow();
    test_underflow_priority();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
